uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers on the txclk domain. It selects one pending requester and loads its byte into the UART with a one-cycle ld_tx_data pulse. It then tracks tx_empty until the frame has fully gone out before granting again. It sits between the producers and the uart transmit port: ld_tx_data, tx_data, tx_enable and tx_empty.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and uart-side signals around uart_tx_arbiter.
// The arbiter connects through the slave modport; the master modport faces producers and the uart.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                          arb_enable;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [ID_W-1:0]               last_gnt_id;
  logic                          busy;
  logic                          ld_tx_data;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_enable;
  logic                          tx_empty;
  logic                          err_timeout;

  modport slave (
    input  arb_enable, req, req_data, tx_empty,
    output gnt, last_gnt_id, busy, ld_tx_data, tx_data, tx_enable, err_timeout
  );

  modport master (
    output arb_enable, req, req_data, tx_empty,
    input  gnt, last_gnt_id, busy, ld_tx_data, tx_data, tx_enable, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart transmitter between NUM_REQ byte producers.
// Optional WAIT_START watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GUARD_CYCLES   = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             txclk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_ID     = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, GUARD} state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        last_id_reg, last_id_next;
  logic [NUM_REQ-1:0]      gnt_reg, gnt_next;
  logic                    ld_reg, ld_next;
  logic                    busy_reg, busy_next;
  logic                    tx_enable_reg;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic [GCNT_W-1:0]       guard_cnt_reg, guard_cnt_next;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W:0]          cand;
  logic                    found;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic              err_reg, err_next;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // First pending request at or above the pointer; the index wraps without
  // ever leaving 0..NUM_REQ-1, even when NUM_REQ is not a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_reg} + (PTR_W + 1)'(i);
      if (cand >= NUM_REQ_EXT) cand = cand - NUM_REQ_EXT;
      if (!found && bus.req[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    last_id_next   = last_id_reg;
    gnt_next       = '0;
    ld_next        = 1'b0;
    tx_data_next   = tx_data_reg;
    guard_cnt_next = guard_cnt_reg;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_next   = tmo_cnt_reg;
    err_next       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.arb_enable && bus.tx_empty && found) begin
          state_next       = LOAD;
          gnt_next[winner] = 1'b1;
          ld_next          = 1'b1;
          tx_data_next     = data_arr[winner];
          last_id_next     = winner;
          ptr_next         = (winner == LAST_ID) ? '0 : winner + PTR_W'(1);
        end
      end
      LOAD: begin
        state_next = WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end
      // tx_empty may still read high from before the load; only a low level
      // proves the uart has taken the byte.
      WAIT_START: begin
        if (!bus.tx_empty) begin
          state_next = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (int'(tmo_cnt_reg) >= TIMEOUT_CYCLES - 1) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TCNT_W'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (bus.tx_empty) begin
          if (GUARD_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next     = GUARD;
            guard_cnt_next = '0;
          end
        end
      end
      GUARD: begin
        if (int'(guard_cnt_reg) >= GUARD_CYCLES - 1) state_next = IDLE;
        else guard_cnt_next = guard_cnt_reg + GCNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      last_id_reg   <= '0;
      gnt_reg       <= '0;
      ld_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      tx_enable_reg <= 1'b0;
      tx_data_reg   <= '0;
      guard_cnt_reg <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      last_id_reg   <= last_id_next;
      gnt_reg       <= gnt_next;
      ld_reg        <= ld_next;
      busy_reg      <= busy_next;
      tx_enable_reg <= 1'b1;
      tx_data_reg   <= tx_data_next;
      guard_cnt_reg <= guard_cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_reg   <= tmo_cnt_next;
      err_reg       <= err_next;
`endif
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.last_gnt_id = last_id_reg;
  assign bus.busy        = busy_reg;
  assign bus.ld_tx_data  = ld_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_enable   = tx_enable_reg;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.err_timeout = err_reg;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic scored against a
// round-robin reference model and a behavioural uart. Honours UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int G   = 3;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TMO)) dut (
    .txclk(clk),
    .reset(reset),
    .bus  (bus)
  );

  int   passed = 0, total = 0, cycle = 0, rise_cycle = 0, exp_ptr = 0;
  bit   rose_since_ld = 1'b0;
  logic prev_empty = 1'b1;

  // Behavioural uart: drops tx_empty start_dly cycles after a load, holds it low frame_len cycles.
  int   frame_len = 10, start_dly = 0, u_start = 0, u_frame = 0;
  bit   force_empty = 1'b0, u_active = 1'b0;
  logic tx_empty_m = 1'b1;
  assign bus.tx_empty = tx_empty_m;

  always @(posedge clk) begin
    if (force_empty) begin
      tx_empty_m <= 1'b1;
      u_active   <= 1'b0;
    end else if (bus.ld_tx_data === 1'b1) begin
      u_active <= 1'b1;
      u_start  <= start_dly;
      u_frame  <= frame_len;
      if (start_dly == 0) tx_empty_m <= 1'b0;
    end else if (u_active) begin
      if (u_start > 0) begin
        u_start <= u_start - 1;
        if (u_start == 1) tx_empty_m <= 1'b0;
      end else if (u_frame > 1) begin
        u_frame <= u_frame - 1;
      end else begin
        tx_empty_m <= 1'b1;
        u_active   <= 1'b0;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (prev_empty === 1'b0 && bus.tx_empty === 1'b1) begin
      rise_cycle    = cycle;
      rose_since_ld = 1'b1;
    end
    prev_empty = bus.tx_empty;
  endtask

  task automatic wait_ld(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.ld_tx_data === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic settle(output bit ok);
    bus.req = '0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus.busy === 1'b0 && bus.tx_empty === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = '0;
    step(); step();
    reset = 1'b0; exp_ptr = 0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.arb_enable = 1'b1; bus.req = '1;
    step(); step();
    total++; if (bus.gnt !== '0) $display("FAIL reset_gnt: got %b want 0", bus.gnt); else passed++;
    total++; if (bus.ld_tx_data !== 1'b0) $display("FAIL reset_ld: got %b want 0", bus.ld_tx_data); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.tx_data !== '0) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else passed++;
    total++; if (bus.last_gnt_id !== '0) $display("FAIL reset_last_id: got %0d want 0", bus.last_gnt_id); else passed++;
    total++; if (bus.tx_enable !== 1'b0) $display("FAIL reset_tx_enable: got %b want 0", bus.tx_enable); else passed++;
    total++; if (bus.err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_timeout); else passed++;
    reset = 1'b0; bus.req = '0; exp_ptr = 0;
    step();
    total++; if (bus.tx_enable !== 1'b1) $display("FAIL post_reset_tx_enable: got %b want 1", bus.tx_enable); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", bus.busy); else passed++;
    $display("test_reset done at cycle %0d", cycle);
  endtask

  task automatic test_single();
    bit ok, seen_low;
    int bad;
    frame_len = 10; start_dly = 0;
    bus.req_data[0 +: DW] = 8'h41; bus.req = 4'b0001;
    wait_ld(50, ok);
    bus.req = '0;
    total++; if (!ok || bus.gnt !== 4'b0001) $display("FAIL single_gnt: got %b (ld seen %0b) want 0001", bus.gnt, ok); else passed++;
    total++; if (bus.tx_data !== 8'h41) $display("FAIL single_data: got %h want 41", bus.tx_data); else passed++;
    total++; if (bus.last_gnt_id !== 2'd0) $display("FAIL single_last_id: got %0d want 0", bus.last_gnt_id); else passed++;
    exp_ptr = 1;
    step();
    total++; if ({bus.ld_tx_data, bus.gnt} !== 5'b0) $display("FAIL single_pulse_width: got ld=%b gnt=%b want 0/0000", bus.ld_tx_data, bus.gnt); else passed++;
    seen_low = 1'b0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy !== 1'b1) bad++;
      if (bus.tx_empty === 1'b0) seen_low = 1'b1;
      else if (seen_low) break;
      step();
    end
    total++; if (bad != 0 || !seen_low) $display("FAIL single_busy: got %0d low-busy cycles (frame seen %0b) want 0/1", bad, seen_low); else passed++;
    $display("test_single done at cycle %0d", cycle);
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    logic [N-1:0] eg;
    logic [DW-1:0] b [N] = '{8'h48, 8'h65, 8'h6C, 8'h6F};
    do_reset();
    frame_len = 10; start_dly = 0; rose_since_ld = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = b[i];
    bus.req = '1;
    for (int g = 0; g < 5; g++) begin
      wait_ld(100, ok);
      e  = rr_pick(bus.req, exp_ptr);
      eg = N'(1) << e;
      total++;
      if (!ok || bus.gnt !== eg || bus.tx_data !== b[e])
        $display("FAIL rr_grant%0d: got gnt=%b data=%h want gnt=%b data=%h", g, bus.gnt, bus.tx_data, eg, b[e]);
      else passed++;
      if (g > 0) begin
        total++;
        if (!rose_since_ld || cycle - rise_cycle != G + 2)
          $display("FAIL rr_spacing%0d: got rise=%0b gap=%0d want 1/%0d", g, rose_since_ld, cycle - rise_cycle, G + 2);
        else passed++;
      end
      $display("rr grant %0d -> requester %0d data %h", g, e, bus.tx_data);
      rose_since_ld = 1'b0;
      exp_ptr = (e + 1) % N;
    end
  endtask

  task automatic test_guard();
    bit ok;
    int e;
    settle(ok);
    frame_len = 5; start_dly = 2; rose_since_ld = 1'b0;
    bus.req_data[0 +: DW] = 8'hC3; bus.req_data[DW +: DW] = 8'h3C; bus.req = 4'b0011;
    for (int g = 0; g < 3; g++) begin
      wait_ld(100, ok);
      e = rr_pick(bus.req, exp_ptr);
      total++;
      if (!ok || bus.last_gnt_id !== 2'(e)) $display("FAIL guard_id%0d: got %0d want %0d", g, bus.last_gnt_id, e); else passed++;
      if (g > 0) begin
        total++;
        if (!rose_since_ld || cycle - rise_cycle != G + 2)
          $display("FAIL guard_gap%0d: got rise=%0b gap=%0d want 1/%0d", g, rose_since_ld, cycle - rise_cycle, G + 2);
        else passed++;
      end
      $display("guard grant %0d -> requester %0d at cycle %0d", g, e, cycle);
      rose_since_ld = 1'b0;
      exp_ptr = (e + 1) % N;
    end
    start_dly = 0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    frame_len = 12; start_dly = 0;
    bus.req_data[2*DW +: DW] = 8'hA5; bus.req = 4'b0100;
    wait_ld(50, ok);
    bus.req = '0;
    step(); step(); step();
    bus.req_data[3*DW +: DW] = 8'h5A; bus.req = 4'b1100; reset = 1'b1;
    step();
    total++; if ({bus.gnt, bus.ld_tx_data, bus.busy} !== 6'b0) $display("FAIL midreset_ctrl: got gnt=%b ld=%b busy=%b want 0", bus.gnt, bus.ld_tx_data, bus.busy); else passed++;
    total++; if (bus.tx_data !== '0 || bus.last_gnt_id !== '0) $display("FAIL midreset_regs: got data=%h id=%0d want 00/0", bus.tx_data, bus.last_gnt_id); else passed++;
    reset = 1'b0; exp_ptr = 0;
    wait_ld(100, ok);
    bus.req = '0;
    total++; if (!ok || bus.gnt !== 4'b0100 || bus.tx_data !== 8'hA5) $display("FAIL midreset_regrant: got gnt=%b data=%h want 0100/a5", bus.gnt, bus.tx_data); else passed++;
    exp_ptr = 3;
    $display("test_reset_midframe done at cycle %0d", cycle);
  endtask

  task automatic test_enable();
    bit ok;
    int cnt;
    settle(ok);
    total++; if (!ok) $display("FAIL enable_settle: got busy=%b want 0", bus.busy); else passed++;
    bus.arb_enable = 1'b0; bus.req_data[DW +: DW] = 8'h3C; bus.req = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.gnt !== '0 || bus.ld_tx_data !== 1'b0) cnt++;
    end
    total++; if (cnt != 0) $display("FAIL enable_off: got %0d grant cycles want 0", cnt); else passed++;
    bus.arb_enable = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (bus.gnt === 4'b0010) begin ok = 1'b1; break; end
    end
    total++; if (!ok || bus.last_gnt_id !== 2'd1) $display("FAIL enable_on: got gnt=%b id=%0d want 0010/1", bus.gnt, bus.last_gnt_id); else passed++;
    exp_ptr = 2;
    bus.arb_enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.ld_tx_data === 1'b1) cnt++;
    end
    total++; if (cnt != 0 || bus.busy !== 1'b0) $display("FAIL enable_drop: got %0d loads busy=%b want 0/0", cnt, bus.busy); else passed++;
    bus.req = '0; bus.arb_enable = 1'b1;
  endtask

  task automatic test_random();
    bit ok;
    int e, grants = 0, k;
    logic [N-1:0] r_prev, eg;
    logic [N*DW-1:0] d_prev;
    settle(ok);
    rose_since_ld = 1'b0;
    for (int c = 0; c < 4000 && grants < 25; c++) begin
      r_prev = bus.req; d_prev = bus.req_data;
      step();
      if (rose_since_ld && cycle == rise_cycle + G + 2 && r_prev != '0) begin
        total++; if (bus.ld_tx_data !== 1'b1) $display("FAIL rand_latency: got ld=%b at gap %0d want 1", bus.ld_tx_data, G + 2); else passed++;
      end
      if (bus.ld_tx_data === 1'b1) begin
        e  = rr_pick(r_prev, exp_ptr);
        eg = (e >= 0) ? N'(1) << e : '0;
        total++;
        if (e < 0 || bus.gnt !== eg || bus.tx_data !== d_prev[e*DW +: DW] || bus.last_gnt_id !== 2'(e))
          $display("FAIL rand_grant%0d: got gnt=%b data=%h id=%0d want gnt=%b requester %0d", grants, bus.gnt, bus.tx_data, bus.last_gnt_id, eg, e);
        else passed++;
        if (grants > 0) begin
          total++;
          if (!rose_since_ld || cycle - rise_cycle < G + 2)
            $display("FAIL rand_spacing%0d: got rise=%0b gap=%0d want 1/>=%0d", grants, rose_since_ld, cycle - rise_cycle, G + 2);
          else passed++;
        end
        $display("rand grant %0d -> requester %0d data %h", grants, e, bus.tx_data);
        grants++;
        rose_since_ld = 1'b0;
        frame_len = $urandom_range(2, 12); start_dly = $urandom_range(0, 2);
        if (e >= 0) begin
          exp_ptr = (e + 1) % N;
          if ($urandom_range(0, 1) == 0) bus.req[e] = 1'b0;
          else bus.req_data[e*DW +: DW] = DW'($urandom);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        if (bus.req[k] === 1'b0) begin
          bus.req_data[k*DW +: DW] = DW'($urandom);
          bus.req[k] = 1'b1;
        end
      end
    end
    total++; if (grants < 25) $display("FAIL rand_progress: got %0d grants want 25", grants); else passed++;
    bus.req = '0; start_dly = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    int c0, err_cnt = 0, err_at = -1, busy_bad = 0;
    logic busy_at_err = 1'bx;
    do_reset();
    force_empty = 1'b1;
    step();
    bus.req_data[0 +: DW] = 8'h77; bus.req = 4'b0001;
    wait_ld(20, ok);
    bus.req = '0;
    c0 = cycle;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.err_timeout === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = cycle;
      end
      if (cycle == c0 + TMO + 1) busy_at_err = bus.busy;
      if (bus.busy !== 1'b1) busy_bad++;
    end
`ifdef UART_ARB_TIMEOUT_EN
    total++; if (!ok || err_cnt != 1 || err_at != c0 + TMO + 1) $display("FAIL timeout_pulse: got %0d pulses first at +%0d want 1 at +%0d", err_cnt, err_at - c0, TMO + 1); else passed++;
    total++; if (busy_at_err !== 1'b0) $display("FAIL timeout_idle: got busy=%b want 0", busy_at_err); else passed++;
`else
    total++; if (!ok || err_cnt != 0) $display("FAIL timeout_err: got %0d pulses (ld seen %0b) want 0", err_cnt, ok); else passed++;
    total++; if (busy_bad != 0 || busy_at_err !== 1'b1) $display("FAIL timeout_busy: got %0d idle cycles want 0", busy_bad); else passed++;
`endif
    $display("test_timeout done at cycle %0d", cycle);
    force_empty = 1'b0;
    do_reset();
  endtask

  initial begin
    bus.arb_enable = 1'b1;
    bus.req        = '0;
    bus.req_data   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_guard();
    test_reset_midframe();
    test_enable();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by cycle %0d want finish", cycle);
    $fatal(1, "watchdog expired");
  end
endmodule
